// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and constants for the async FIFO read-side stream adapter.
//   rd_stream_state_e : occupancy state of the 2-entry output buffer
//   RD_STREAM_DEPTH   : number of words the output buffer can hold
//   state_words()     : maps a buffer state to its word count (0..2)
// Optional feature macro used by consumers: ASYNC_FIFO_RD_BEAT_CNT_EN
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } rd_stream_state_e;

    localparam int RD_STREAM_DEPTH = 2;

    function automatic logic [1:0] state_words(input rd_stream_state_e st);
        logic [1:0] words;
        case (st)
            ST_ONE:  words = 2'd1;
            ST_TWO:  words = 2'd2;
            default: words = 2'd0;
        endcase
        return words;
    endfunction

endpackage : async_fifo_pkg

// File: rtl/async_fifo_beat_cnt.sv
// -----------------------------------------------------------------------------
// async_fifo_beat_cnt
// Saturating up-counter of accepted stream beats. Sticks at all-ones instead
// of wrapping; only reset clears it.
// Ports:
//   clk   in   read-domain clock
//   reset in   synchronous, active-high reset
//   inc   in   count one beat this cycle
//   cnt   out  current count, CNT_WIDTH bits
// Only instantiated when ASYNC_FIFO_RD_BEAT_CNT_EN is defined.
// -----------------------------------------------------------------------------
module async_fifo_beat_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : async_fifo_beat_cnt

// File: rtl/async_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_stream
// Read-side stream adapter for the async FIFO core. Turns the core's
// ren/rdata/rempty port into a registered valid/ready master stream using a
// main register (drives m_data) plus one skid register, giving one word per
// clock with no combinational path from m_ready to fifo_ren.
//
// State table:
//   state    | meaning
//   ST_EMPTY | no word buffered, m_valid low
//   ST_ONE   | word in main, skid free, may still read from core
//   ST_TWO   | word in main and skid, reads from core stopped
//
// Ports:
//   clk          in   read-domain clock (core rclk)
//   reset        in   synchronous, active-high reset
//   fifo_ren     out  read strobe to core ren
//   fifo_rdata   in   core rdata, valid while fifo_rempty is low
//   fifo_rempty  in   core rempty (registered in the core)
//   m_valid      out  output word valid
//   m_ready      in   downstream accepts the word
//   m_data       out  output word (main register)
//   buf_count    out  words held, 0..2
//   beat_cnt     out  accepted-beat count (zero unless macro defined)
// Macro: ASYNC_FIFO_RD_BEAT_CNT_EN enables the saturating beat counter.
// -----------------------------------------------------------------------------
module async_fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    rd_stream_state_e      state_q;
    rd_stream_state_e      state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  push;
    logic                  pop;

    // Read decision looks only at occupancy and rempty, so m_ready never
    // reaches the core combinationally.
    assign fifo_ren = !reset && !fifo_rempty && (state_q != ST_TWO);

    assign push = fifo_ren;
    assign pop  = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    main_d  = fifo_rdata;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = fifo_rdata;
                end else if (push) begin
                    // Downstream stalled: park the extra word in skid.
                    state_d = ST_TWO;
                    skid_d  = fifo_rdata;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign m_valid   = (state_q != ST_EMPTY);
    assign m_data    = main_q;
    assign buf_count = state_words(state_q);

`ifdef ASYNC_FIFO_RD_BEAT_CNT_EN
    async_fifo_beat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .cnt   (beat_cnt)
    );
`else
    assign beat_cnt = '0;
`endif

endmodule : async_fifo_rd_stream
